// File: rtl/crc_frame_rx_if.sv
// Byte-stream input and frame output handshake bundle for crc_frame_rx.
// slave is the receiver side; master is the producer/consumer environment.
interface crc_frame_rx_if #(
  parameter int PAYLOAD_BYTES = 5
) ();
  localparam int PW = 8 * PAYLOAD_BYTES;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_sof;
  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] out_payload;
  logic          out_crc_ok;
  logic          out_ready;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_payload, out_crc_ok
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_payload, out_crc_ok
  );
endinterface

// File: rtl/crc_frame_rx.sv
// Frame receiver: collects PAYLOAD_BYTES payload bytes plus one CRC-8 byte,
// checks the remainder and holds the frame until the consumer takes it.
module crc_frame_rx #(
  parameter int          PAYLOAD_BYTES = 5,
  parameter logic [7:0]  DIVISOR       = 8'b0000_0111
) (
  input  logic           clk,
  input  logic           rst_n,
  crc_frame_rx_if.slave  bus,
  output logic [7:0]     err_cnt,
  output logic [7:0]     resync_cnt
);
  localparam int PW = 8 * PAYLOAD_BYTES;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] byte_cnt_reg, byte_cnt_next;
  logic [7:0]    rem_reg, rem_next;
  logic [PW-1:0] payload_reg, payload_next;
  logic          crc_ok_reg, crc_ok_next;
  logic [7:0]    err_cnt_reg, err_cnt_next;
  logic [7:0]    resync_cnt_reg, resync_cnt_next;

  logic          accept;
  logic          restart;
  logic          last_byte;
  logic [CW-1:0] byte_idx;
  logic [7:0]    rem_base;
  logic [7:0]    rem_upd;

  // One full byte of MSB-first polynomial division in a single step.
  function automatic logic [7:0] crc_byte(input logic [7:0] rem, input logic [7:0] data);
    logic [7:0] r;
    r = rem;
    for (int i = 7; i >= 0; i--) begin
      if (r[7]) r = {r[6:0], data[i]} ^ DIVISOR;
      else      r = {r[6:0], data[i]};
    end
    return r;
  endfunction

  // A start-of-frame mid-frame re-bases the byte as index 0 with a fresh remainder.
  always_comb begin
    accept    = (state_reg == COLLECT) && bus.in_valid;
    restart   = accept && bus.in_sof && (byte_cnt_reg != '0);
    byte_idx  = restart ? '0 : byte_cnt_reg;
    rem_base  = restart ? 8'h00 : rem_reg;
    rem_upd   = crc_byte(rem_base, bus.in_data);
    last_byte = (byte_idx == LAST_IDX);
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_reg)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (accept && last_byte) state_next = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    byte_cnt_next   = byte_cnt_reg;
    rem_next        = rem_reg;
    payload_next    = payload_reg;
    crc_ok_next     = crc_ok_reg;
    err_cnt_next    = err_cnt_reg;
    resync_cnt_next = resync_cnt_reg;
    if (accept) begin
      if (restart && (resync_cnt_reg != 8'hFF)) resync_cnt_next = resync_cnt_reg + 8'd1;
      if (last_byte) begin
        crc_ok_next   = (rem_upd == 8'h00);
        byte_cnt_next = '0;
        rem_next      = 8'h00;
        if ((rem_upd != 8'h00) && (err_cnt_reg != 8'hFF)) err_cnt_next = err_cnt_reg + 8'd1;
      end else begin
        payload_next  = (payload_reg << 8) | PW'(bus.in_data);
        byte_cnt_next = byte_idx + CW'(1);
        rem_next      = rem_upd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= COLLECT;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg   <= '0;
      rem_reg        <= 8'h00;
      payload_reg    <= '0;
      crc_ok_reg     <= 1'b0;
      err_cnt_reg    <= 8'h00;
      resync_cnt_reg <= 8'h00;
    end else begin
      byte_cnt_reg   <= byte_cnt_next;
      rem_reg        <= rem_next;
      payload_reg    <= payload_next;
      crc_ok_reg     <= crc_ok_next;
      err_cnt_reg    <= err_cnt_next;
      resync_cnt_reg <= resync_cnt_next;
    end
  end

  assign bus.out_payload = payload_reg;
  assign bus.out_crc_ok  = crc_ok_reg;
  assign err_cnt         = err_cnt_reg;
  assign resync_cnt      = resync_cnt_reg;
endmodule

// File: tb/tb_crc_frame_rx.sv
// Scoreboard bench for crc_frame_rx: a byte-level frame model predicts each
// frame, a monitor compares whenever the receiver presents one.
module tb_crc_frame_rx;
  localparam int         PB  = 5;
  localparam int         PW  = 8 * PB;
  localparam logic [7:0] DIV = 8'h07;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] err_cnt;
  logic [7:0] resync_cnt;

  always #5 clk = ~clk;

  crc_frame_rx_if #(.PAYLOAD_BYTES(PB)) bus ();

  crc_frame_rx #(.PAYLOAD_BYTES(PB), .DIVISOR(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_cnt    (err_cnt),
    .resync_cnt (resync_cnt)
  );

  typedef struct packed {
    logic [PW-1:0] payload;
    logic          ok;
    logic [7:0]    err;
    logic [7:0]    resync;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] partial[$];
  logic [7:0] stim[$];
  int         m_err, m_resync;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         rand_ready_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Remainder of the message polynomial divided by x^8 + DIV (long division).
  function automatic logic [7:0] poly_mod(input logic [63:0] m);
    logic [63:0] r, g;
    r = m;
    g = {55'b0, 1'b1, DIV};
    for (int i = 63; i >= 8; i--)
      if (r[i]) r = r ^ (g << (i - 8));
    return r[7:0];
  endfunction

  task automatic model_accept(input logic [7:0] d, input logic sof, output bit done);
    logic [63:0] msg;
    exp_t e;
    done = 0;
    if (sof && partial.size() != 0) begin
      partial.delete();
      if (m_resync < 255) m_resync++;
    end
    partial.push_back(d);
    if (partial.size() == PB + 1) begin
      msg = 64'd0;
      foreach (partial[i]) msg = (msg << 8) | 64'(partial[i]);
      e.payload = msg[PW+7:8];
      e.ok      = (poly_mod(msg) == 8'h00);
      if (!e.ok && m_err < 255) m_err++;
      e.err     = m_err[7:0];
      e.resync  = m_resync[7:0];
      expq.push_back(e);
      partial.delete();
      done = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof);
    int waited = 0;
    bit acc, done;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = sof;
    do begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 200);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      model_accept(d, sof, done);
      if (done) check("latency_valid", bus.out_valid, 1);
    end
  endtask

  task automatic send_seq(input bit first_sof);
    foreach (stim[i]) send_byte(stim[i], (i == 0) && first_sof);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((expq.size() != 0 || bus.out_valid) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 300) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d frames still pending, required 0", expq.size());
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_payload", bus.out_payload, 0);
    check("rst_crc_ok", bus.out_crc_ok, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_resync_cnt", resync_cnt, 0);
    partial.delete();
    expq.delete();
    m_err = 0;
    m_resync = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);
  endtask

  task automatic send_random_frame(input bit sof_first, input bit force_bad);
    logic [63:0] tmp;
    logic [PW-1:0] p;
    logic [7:0] crc;
    tmp = {$urandom(), $urandom()};
    p = tmp[PW-1:0];
    crc = poly_mod(64'(p) << 8);
    if (force_bad || $urandom_range(0, 1) == 1) crc = crc ^ 8'($urandom_range(1, 255));
    for (int i = 0; i < PB; i++) begin
      send_byte(p[PW-1-8*i -: 8], (i == 0) && sof_first);
      if (!force_bad && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    send_byte(crc, 1'b0);
  endtask

  // Ready randomiser used only during the random phase.
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops one expectation per presented frame, then checks it stays stable.
  exp_t cur;
  bit   held = 0, prev_hs = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      held = 0;
      prev_hs = 0;
    end else begin
      if (prev_hs) check("valid_drop", bus.out_valid, 0);
      prev_hs = 0;
      if (bus.out_valid === 1'b1) begin
        if (!held) begin
          if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: out_valid=1 payload %0h, required no frame", bus.out_payload);
          end else begin
            cur = expq.pop_front();
            check("frame_payload", bus.out_payload, cur.payload);
            check("frame_crc_ok", bus.out_crc_ok, cur.ok);
            check("frame_err_cnt", err_cnt, cur.err);
            check("frame_resync_cnt", resync_cnt, cur.resync);
          end
          held = 1;
        end else begin
          check("hold_payload", bus.out_payload, cur.payload);
          check("hold_crc_ok", bus.out_crc_ok, cur.ok);
        end
        check("hold_in_ready", bus.in_ready, 0);
        if (bus.out_ready) begin
          held = 0;
          prev_hs = 1;
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h07};
    send_seq(1'b1);
    wait_drain();
    check("good_frame_err_cnt", err_cnt, 0);

    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h06};
    send_seq(1'b1);
    wait_drain();
    check("bad_frame_err_cnt", err_cnt, 1);

    stim = '{8'hAA, 8'hBB, 8'hCC};
    send_seq(1'b1);
    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h07};
    send_seq(1'b1);
    wait_drain();
    check("resync_cnt_after_truncation", resync_cnt, 1);

    bus.out_ready = 1'b0;
    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(1'b1);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid_held", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_drop", bus.out_valid, 0);

    stim = '{8'h11, 8'h22, 8'h33};
    send_seq(1'b1);
    do_reset();
    send_random_frame(1'b1, 1'b0);
    wait_drain();

    bus.out_ready = 1'b0;
    send_random_frame(1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    do_reset();
    bus.out_ready = 1'b1;
    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h07};
    send_seq(1'b0);
    wait_drain();

    rand_ready_en = 1;
    repeat (150) begin
      if ($urandom_range(0, 9) == 0) begin
        int k;
        k = $urandom_range(1, PB);
        for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)), i == 0);
        send_random_frame(1'b1, 1'b0);
      end else begin
        send_random_frame($urandom_range(0, 3) != 0, 1'b0);
      end
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end
    rand_ready_en = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain();

    do_reset();
    repeat (256) send_random_frame(1'b1, 1'b1);
    wait_drain();
    check("err_cnt_saturated", err_cnt, 8'hFF);
    check("resync_cnt_untouched", resync_cnt, 0);
    check("scoreboard_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/crc_frame_rx.md
CRC_FRAME_RX -- requirements
Module: crc_frame_rx

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 5, the number of payload bytes per frame (payload width PW = 8*PAYLOAD_BYTES).
REQ-002 SHALL have parameter DIVISOR, default 8'b0000_0111, the CRC-8 generator polynomial with the implicit x^8 term omitted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data holds a byte.
REQ-006 SHALL have port in_data, input, 8 bits: frame byte, MSB-first.
REQ-007 SHALL have port in_sof, input, 1 bit: qualified by in_valid; marks the byte as the first byte of a frame.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: a completed frame is presented.
REQ-010 SHALL have port out_payload, output, PW bits: the frame payload; the first received byte lands in [PW-1:PW-8].
REQ-011 SHALL have port out_crc_ok, output, 1 bit: the frame remainder is zero; qualified by out_valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the frame.
REQ-013 SHALL have port err_cnt, output, 8 bits: saturating count of CRC failures.
REQ-014 SHALL have port resync_cnt, output, 8 bits: saturating count of truncated frames.

Function
REQ-015 A frame SHALL be PAYLOAD_BYTES payload bytes followed by one CRC byte (PAYLOAD_BYTES+1 bytes total).
REQ-016 A byte SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-017 The CRC SHALL be computed MSB-first, non-reflected, with initial remainder 8'h00 and no final XOR.
- The running 8-bit remainder is updated once per accepted byte.
- Each update shifts in all 8 bits combinationally: if the remainder MSB is 1, shift left, insert the data bit, then XOR with DIVISOR; otherwise shift left and insert the data bit.
REQ-018 out_crc_ok SHALL be 1 exactly when the remainder over all PW+8 frame bits equals 8'h00.
REQ-019 The FSM SHALL have two states, COLLECT and HOLD, and SHALL reset into COLLECT.
REQ-020 In COLLECT, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-021 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-022 byte_cnt SHALL count from 0 to PAYLOAD_BYTES and increment on each accepted byte.
REQ-023 Each accepted payload byte SHALL shift into the payload register from the LSB end.
REQ-024 On acceptance of byte index PAYLOAD_BYTES (the CRC byte), the FSM SHALL go to HOLD, latch out_crc_ok, and clear byte_cnt and the remainder.
REQ-025 out_valid SHALL rise in the cycle after the CRC byte is accepted (latency 1 cycle).
REQ-026 out_payload and out_crc_ok SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 In HOLD, out_valid=1 with out_ready=1 SHALL return the FSM to COLLECT on the next edge; minimum frame period is PAYLOAD_BYTES+2 cycles.
REQ-028 err_cnt SHALL increment by 1 on entry to HOLD when the latched out_crc_ok is 0, and SHALL saturate at 8'hFF.
REQ-029 An accepted byte with in_sof=1 while byte_cnt!=0 SHALL discard the partial frame, increment resync_cnt (saturating at 8'hFF), and treat that byte as byte 0 with the remainder restarted from 8'h00.
REQ-030 An accepted byte with in_sof=0 while byte_cnt=0 SHALL be accepted as byte 0; in_sof is not required for framing.
REQ-031 in_valid in HOLD SHALL be ignored: no byte is consumed and no state changes.

Reset
REQ-032 Assertion of rst_n=0 SHALL immediately, regardless of clk, force:
- state = COLLECT, byte_cnt = 0, remainder = 8'h00;
- out_valid = 0, out_payload = 0, out_crc_ok = 0;
- err_cnt = 0, resync_cnt = 0.
REQ-033 Reset mid-frame or in HOLD SHALL drop the frame without emitting it.
REQ-034 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-035 Send bytes 00 00 00 00 01 07 with out_ready=1 -> one cycle with out_valid=1, out_payload=40'h0000000001, out_crc_ok=1, err_cnt=0.
REQ-036 Send bytes 00 00 00 00 01 06 -> out_crc_ok=0 and err_cnt=1.
REQ-037 Send an all-zero frame with out_ready=0 for 5 cycles -> out_valid held for those 5 cycles with stable payload and in_ready=0; out_valid drops 1 cycle after out_ready=1.
REQ-038 Send 3 bytes, then bytes 00 00 00 00 01 07 with in_sof=1 on the first 00 -> resync_cnt=1 and out_crc_ok=1 for payload 40'h0000000001.
REQ-039 Drive rst_n low while byte_cnt=3 or in HOLD -> out_valid=0 immediately; the next good frame is received correctly.
REQ-040 Drive 256 bad-CRC frames -> err_cnt saturates at 8'hFF.
